mem_stage: RTL and testbench

- RV64 load/store stage directly downstream of the ALU.
- Consumes the registered ALU result (`data_out`, `aluRegDest`, `wr_en`) as either an effective address or a plain result.
- Loads and stores go through a single-outstanding request/response data-memory port; all other results pass straight through.
- Produces one registered writeback beat per accepted instruction for the register file.

---
 rtl/mem_stage.sv | 207 ++++++++++++++++++++
 tb/tb_mem_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// RV64 load/store stage behind the ALU: non-memory results pass through in one cycle,
// loads/stores use a single-outstanding request/response memory port.
module mem_stage #(
    parameter int XLEN             = 64,
    parameter bit LOAD_ONLY_BYPASS = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_is_load,
    input  logic            in_is_store,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] in_store_data,
    input  logic [4:0]      in_rd,
    input  logic            in_wr_en,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    output logic            mem_req_write,
    output logic [XLEN-1:0] mem_req_wdata,
    output logic [7:0]      mem_req_wstrb,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_resp_rdata,
    output logic            wb_valid,
    output logic            wb_wr_en,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_misaligned
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        f3_q, f3_d;
    logic [2:0]        off_q, off_d;
    logic [4:0]        rd_q, rd_d;
    logic              wr_en_q, wr_en_d;
    logic              is_store_q, is_store_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [7:0]        wstrb_q, wstrb_d;
    logic              write_q, write_d;
    logic              wb_valid_q, wb_valid_d;
    logic              wb_wr_en_q, wb_wr_en_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    logic              wb_mis_q, wb_mis_d;

    logic accept, is_mem, is_store;

    function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] lo);
        case (sz)
            2'b01:   return lo[0];
            2'b10:   return |lo[1:0];
            2'b11:   return |lo[2:0];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] store_strb(input logic [1:0] sz, input logic [2:0] off);
        case (sz)
            2'b00:   return 8'h01 << off;
            2'b01:   return 8'h03 << off;
            2'b10:   return 8'h0F << off;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] rdata,
                                                     input logic [2:0] f3,
                                                     input logic [2:0] off);
        logic [XLEN-1:0] s;
        s = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  return {{(XLEN-8){s[7]}}, s[7:0]};
            3'b001:  return {{(XLEN-16){s[15]}}, s[15:0]};
            3'b010:  return {{(XLEN-32){s[31]}}, s[31:0]};
            3'b100:  return {{(XLEN-8){1'b0}}, s[7:0]};
            3'b101:  return {{(XLEN-16){1'b0}}, s[15:0]};
            3'b110:  return {{(XLEN-32){1'b0}}, s[31:0]};
            default: return s;
        endcase
    endfunction

    // A nonzero bypass setting is unsupported; it keeps the stage from accepting work.
    assign in_ready      = (state_q == IDLE) && (LOAD_ONLY_BYPASS == 1'b0);
    assign accept        = in_valid && in_ready;
    assign is_mem        = in_is_load || in_is_store;
    assign is_store      = in_is_store && !in_is_load;

    assign mem_req_valid = (state_q == REQ);
    assign mem_req_addr  = addr_q;
    assign mem_req_write = write_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_wstrb = wstrb_q;
    assign wb_valid      = wb_valid_q;
    assign wb_wr_en      = wb_wr_en_q;
    assign wb_rd         = wb_rd_q;
    assign wb_data       = wb_data_q;
    assign wb_misaligned = wb_mis_q;

    always_comb begin
        state_d    = state_q;
        f3_d       = f3_q;
        off_d      = off_q;
        rd_d       = rd_q;
        wr_en_d    = wr_en_q;
        is_store_d = is_store_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        write_d    = write_q;
        wb_valid_d = 1'b0;
        wb_wr_en_d = wb_wr_en_q;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        wb_mis_d   = wb_mis_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!is_mem) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = in_alu_result;
                        wb_rd_d    = in_rd;
                        wb_wr_en_d = in_wr_en && (in_rd != 5'd0);
                        wb_mis_d   = 1'b0;
                    end else if (misaligned(in_funct3[1:0], in_alu_result[2:0])) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = in_alu_result;
                        wb_rd_d    = in_rd;
                        wb_wr_en_d = 1'b0;
                        wb_mis_d   = 1'b1;
                    end else begin
                        f3_d       = in_funct3;
                        off_d      = in_alu_result[2:0];
                        rd_d       = in_rd;
                        wr_en_d    = in_wr_en;
                        is_store_d = is_store;
                        addr_d     = {in_alu_result[XLEN-1:3], 3'b000};
                        wdata_d    = in_store_data << {in_alu_result[2:0], 3'b000};
                        wstrb_d    = is_store ? store_strb(in_funct3[1:0], in_alu_result[2:0]) : 8'h00;
                        write_d    = is_store;
                        state_d    = REQ;
                    end
                end
            end
            REQ: begin
                if (mem_req_ready) state_d = WAIT;
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    state_d    = DONE;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_mis_d   = 1'b0;
                    if (is_store_q) begin
                        wb_wr_en_d = 1'b0;
                    end else begin
                        wb_wr_en_d = wr_en_q && (rd_q != 5'd0);
                        wb_data_d  = load_extract(mem_resp_rdata, f3_q, off_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            f3_q       <= 3'd0;
            off_q      <= 3'd0;
            rd_q       <= 5'd0;
            wr_en_q    <= 1'b0;
            is_store_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= 8'h00;
            write_q    <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_wr_en_q <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= '0;
            wb_mis_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            f3_q       <= f3_d;
            off_q      <= off_d;
            rd_q       <= rd_d;
            wr_en_q    <= wr_en_d;
            is_store_q <= is_store_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            write_q    <= write_d;
            wb_valid_q <= wb_valid_d;
            wb_wr_en_q <= wb_wr_en_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            wb_mis_q   <= wb_mis_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed cases plus randomized ops checked against a byte-level
// memory model and a rule-based writeback model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_is_load, in_is_store, in_wr_en;
    logic [2:0]  in_funct3;
    logic [63:0] in_alu_result, in_store_data;
    logic [4:0]  in_rd;
    logic        mem_req_valid, mem_req_ready, mem_req_write;
    logic [63:0] mem_req_addr, mem_req_wdata;
    logic [7:0]  mem_req_wstrb;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_rdata;
    logic        wb_valid, wb_wr_en, wb_misaligned;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] mem_model [logic [63:0]];

    mem_stage #(.XLEN(64), .LOAD_ONLY_BYPASS(1'b0)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_is_load(in_is_load), .in_is_store(in_is_store), .in_funct3(in_funct3),
        .in_alu_result(in_alu_result), .in_store_data(in_store_data),
        .in_rd(in_rd), .in_wr_en(in_wr_en),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_write(mem_req_write),
        .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .wb_valid(wb_valid), .wb_wr_en(wb_wr_en), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_misaligned(wb_misaligned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mem_read(input logic [63:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return {a[31:0] ^ 32'hA5C3_1E77, ~a[31:0]};
    endfunction

    // Expected load result assembled byte by byte from the aligned word.
    function automatic logic [63:0] exp_load(input logic [63:0] word, input logic [2:0] f3,
                                             input int off);
        int size;
        logic [63:0] v;
        logic [7:0]  b;
        size = 1 << f3[1:0];
        v = 64'd0;
        for (int i = 0; i < size; i++) begin
            b = word[8*(off+i) +: 8];
            v = v | (64'(b) << (8*i));
        end
        if (!f3[2] && size < 8 && v[8*size-1])
            v = v | ~((64'd1 << (8*size)) - 64'd1);
        return v;
    endfunction

    task automatic run_op(input bit ld, input bit st, input logic [2:0] f3,
                          input logic [63:0] addr, input logic [63:0] sdata,
                          input logic [4:0] rd, input bit we,
                          input int stall, input int rwait);
        bit          mem_op, store, mis;
        int          size, off;
        logic [63:0] base, word, exp_wdata, exp_data;
        logic [7:0]  exp_strb;
        mem_op = ld || st;
        store  = st && !ld;
        size   = 1 << f3[1:0];
        off    = int'(addr % 8);
        mis    = mem_op && ((addr % size) != 0);
        base   = addr - 64'(off);
        exp_strb = 8'h00;
        if (store)
            for (int i = 0; i < size; i++) exp_strb[off+i] = 1'b1;
        exp_wdata = sdata << (8*off);

        chk("in_ready_idle", in_ready, 1);
        in_valid = 1'b1; in_is_load = ld; in_is_store = st; in_funct3 = f3;
        in_alu_result = addr; in_store_data = sdata; in_rd = rd; in_wr_en = we;
        @(negedge clk);
        in_valid = 1'b0;

        if (!mem_op || mis) begin
            chk("pt_wb_valid", wb_valid, 1);
            chk("pt_wb_data", wb_data, addr);
            chk("pt_wb_rd", wb_rd, rd);
            chk("pt_wb_wr_en", wb_wr_en, (!mis && we && rd != 0) ? 1 : 0);
            chk("pt_wb_mis", wb_misaligned, mis);
            chk("pt_no_req", mem_req_valid, 0);
            return;
        end

        for (int c = 0; c < 20; c++) begin
            chk("req_valid", mem_req_valid, 1);
            chk("req_addr", mem_req_addr, base);
            chk("req_write", mem_req_write, store);
            chk("req_wstrb", mem_req_wstrb, exp_strb);
            if (store) chk("req_wdata", mem_req_wdata, exp_wdata);
            chk("req_in_ready", in_ready, 0);
            chk("req_wb_quiet", wb_valid, 0);
            mem_req_ready  = (c >= stall);
            mem_resp_valid = 1'($urandom_range(0, 1));
            mem_resp_rdata = {$urandom, $urandom};
            @(negedge clk);
            if (c >= stall) break;
        end
        mem_req_ready = 1'b0;

        word = mem_read(base);
        for (int c = 0; c <= rwait; c++) begin
            chk("wait_req_low", mem_req_valid, 0);
            chk("wait_in_ready", in_ready, 0);
            chk("wait_wb_quiet", wb_valid, 0);
            mem_resp_valid = (c == rwait);
            mem_resp_rdata = (c == rwait) ? word : {$urandom, $urandom};
            @(negedge clk);
        end
        mem_resp_valid = 1'b0;

        chk("done_wb_valid", wb_valid, 1);
        chk("done_wb_rd", wb_rd, rd);
        chk("done_wb_mis", wb_misaligned, 0);
        if (store) begin
            chk("done_st_wr_en", wb_wr_en, 0);
            for (int i = 0; i < 8; i++)
                if (exp_strb[i]) word[8*i +: 8] = exp_wdata[8*i +: 8];
            mem_model[base] = word;
        end else begin
            exp_data = exp_load(word, f3, off);
            chk("done_ld_wr_en", wb_wr_en, (we && rd != 0) ? 1 : 0);
            chk("done_ld_data", wb_data, exp_data);
        end
        @(negedge clk);
        chk("after_wb_quiet", wb_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
        in_funct3 = 3'd0; in_alu_result = 64'd0; in_store_data = 64'd0;
        in_rd = 5'd0; in_wr_en = 1'b0; mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0; mem_resp_rdata = 64'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        chk("rst_in_ready", in_ready, 1);
        chk("rst_req_valid", mem_req_valid, 0);
        chk("rst_req_write", mem_req_write, 0);
        chk("rst_req_addr", mem_req_addr, 0);
        chk("rst_req_wdata", mem_req_wdata, 0);
        chk("rst_req_wstrb", mem_req_wstrb, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_wr_en", wb_wr_en, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_mis", wb_misaligned, 0);

        run_op(0, 0, 3'd0, 64'h1234, 64'd0, 5'd5, 1, 0, 0);
        run_op(0, 0, 3'd0, 64'h1234, 64'd0, 5'd0, 1, 0, 0);
        mem_model[64'h1000] = 64'h0000_0000_8000_0000;
        run_op(1, 0, 3'b000, 64'h1003, 64'd0, 5'd7, 1, 0, 0);
        run_op(1, 0, 3'b100, 64'h1003, 64'd0, 5'd7, 1, 0, 0);
        run_op(0, 1, 3'b001, 64'h2006, 64'hABCD, 5'd3, 1, 0, 0);
        run_op(1, 0, 3'b010, 64'h3002, 64'd0, 5'd9, 1, 0, 0);
        run_op(1, 0, 3'b011, 64'h4008, 64'd0, 5'd10, 1, 3, 2);
        run_op(1, 1, 3'b001, 64'h2006, 64'd0, 5'd11, 1, 1, 1);

        // Reset while waiting on a response; the late response must be dropped.
        in_valid = 1'b1; in_is_load = 1'b1; in_is_store = 1'b0; in_funct3 = 3'b011;
        in_alu_result = 64'h5000; in_rd = 5'd12; in_wr_en = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rstw_req_valid", mem_req_valid, 1);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstw_in_ready", in_ready, 1);
        chk("rstw_req_low", mem_req_valid, 0);
        chk("rstw_wb_quiet", wb_valid, 0);
        mem_resp_valid = 1'b1; mem_resp_rdata = 64'hDEAD_BEEF_0000_0001;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        chk("rstw_late_wb", wb_valid, 0);
        chk("rstw_late_ready", in_ready, 1);
        @(negedge clk);
        chk("rstw_late_wb2", wb_valid, 0);

        for (int n = 0; n < 300; n++) begin
            int k;
            bit ld, st;
            logic [2:0] f3;
            k  = int'($urandom_range(0, 9));
            ld = (k >= 3 && k <= 6) || k == 9;
            st = k >= 7;
            f3 = st && !ld ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            run_op(ld, st, f3, {52'd0, 12'($urandom)}, {$urandom, $urandom},
                   5'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
